// File: rtl/card_pkg.sv
// Shared types and helpers for the card match game: sizes, FSM states,
// and symbol extraction from the 48-bit card map.
package card_pkg;
  localparam int NUM_CARDS = 16;
  localparam int NUM_PAIRS = 8;
  localparam int SYM_W     = 3;
  localparam int IDX_W     = 4;
  localparam int MAP_W     = 48;

  typedef enum logic [2:0] {
    IDLE, DEAL, WAIT1, WAIT2, COMPARE, HOLD, WIN
  } state_e;

  // Card c occupies map[3*c +: 3]; base is built in 6 bits to keep the select exact.
  function automatic logic [SYM_W-1:0] sym_of(input logic [0:MAP_W-1] m,
                                               input logic [IDX_W-1:0] idx);
    logic [5:0] base;
    base = {1'b0, idx, 1'b0} + {2'b00, idx};
    return m[base +: SYM_W];
  endfunction
endpackage

// File: rtl/card_match_engine_if.sv
// Generator handshake and player flip channel of the card match engine.
interface card_match_engine_if;
  import card_pkg::*;
  logic                  gen_start;
  logic                  gen_done;
  logic [0:MAP_W-1]      gen_map;
  logic                  flip_valid;
  logic [IDX_W-1:0]      flip_idx;
  logic                  flip_ready;

  modport master (input gen_start, flip_ready,
                  output gen_done, gen_map, flip_valid, flip_idx);
  modport slave  (output gen_start, flip_ready,
                  input gen_done, gen_map, flip_valid, flip_idx);
endinterface

// File: rtl/card_hold_timer.sv
// Countdown for the mismatch display window; expire is high on the last
// counting cycle, when the count has reached zero.
module card_hold_timer #(
  parameter int HOLD_W = 26
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              count,
  output logic              expire
);
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                       cnt_d = load_val;
    else if (count && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire = count && (cnt_q == '0);
endmodule

// File: rtl/card_match_engine.sv
// Memory-style card game: deals via the map generator, pairs flips, holds
// mismatches face up, tracks matches/moves/win. CARD_MATCH_PEEK_EN adds a peek input.
module card_match_engine
  import card_pkg::*;
#(
  parameter int MISMATCH_HOLD = 50_000_000,
  parameter int HOLD_W        = 26
) (
  input  logic                  clk,
  input  logic                  resetn,
`ifdef CARD_MATCH_PEEK_EN
  input  logic                  peek,
`endif
  card_match_engine_if.slave    bus,
  input  logic                  new_game,
  output logic [0:MAP_W-1]      map,
  output logic [NUM_CARDS-1:0]  face_up,
  output logic [NUM_CARDS-1:0]  matched,
  output logic [7:0]            moves,
  output logic                  match_pulse,
  output logic                  miss_pulse,
  output logic                  game_over
);
  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       first_q, first_d, second_q, second_d;
  logic [0:MAP_W-1]       map_q, map_d;
  logic [NUM_CARDS-1:0]   face_up_q, face_up_d, matched_q, matched_d;
  logic [7:0]             moves_q, moves_d;
  logic [3:0]             pairs_q, pairs_d;
  logic                   gen_start_q, gen_start_d, flip_ready_q, flip_ready_d;
  logic                   match_pulse_q, match_pulse_d, miss_pulse_q, miss_pulse_d;
  logic                   game_over_q, game_over_d;
  logic                   timer_load, timer_expire, flip_ok;

  card_hold_timer #(.HOLD_W(HOLD_W)) u_hold (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (HOLD_W'(MISMATCH_HOLD - 1)),
    .count    (state_q == HOLD),
    .expire   (timer_expire)
  );

  // Face-up already covers matched cards and the first card of the pair.
  assign flip_ok = bus.flip_valid && !face_up_q[bus.flip_idx];

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    second_d      = second_q;
    map_d         = map_q;
    face_up_d     = face_up_q;
    matched_d     = matched_q;
    moves_d       = moves_q;
    pairs_d       = pairs_q;
    gen_start_d   = 1'b0;
    match_pulse_d = 1'b0;
    miss_pulse_d  = 1'b0;
    timer_load    = 1'b0;
    if (new_game && state_q != DEAL) begin
      state_d     = DEAL;
      gen_start_d = 1'b1;
      face_up_d   = '0;
      matched_d   = '0;
      moves_d     = '0;
      pairs_d     = '0;
    end else begin
      case (state_q)
        DEAL: if (bus.gen_done) begin
          map_d   = bus.gen_map;
          state_d = WAIT1;
        end
        WAIT1: if (flip_ok) begin
          first_d                 = bus.flip_idx;
          face_up_d[bus.flip_idx] = 1'b1;
          state_d                 = WAIT2;
        end
        WAIT2: if (flip_ok) begin
          second_d                = bus.flip_idx;
          face_up_d[bus.flip_idx] = 1'b1;
          state_d                 = COMPARE;
        end
        COMPARE: begin
          moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          if (sym_of(map_q, first_q) == sym_of(map_q, second_q)) begin
            matched_d[first_q]  = 1'b1;
            matched_d[second_q] = 1'b1;
            match_pulse_d       = 1'b1;
            pairs_d             = pairs_q + 4'd1;
            state_d = (pairs_q == 4'(NUM_PAIRS - 1)) ? WIN : WAIT1;
          end else begin
            timer_load = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: if (timer_expire) begin
          face_up_d[first_q]  = 1'b0;
          face_up_d[second_q] = 1'b0;
          miss_pulse_d        = 1'b1;
          state_d             = WAIT1;
        end
        IDLE, WIN: ;
        default: state_d = IDLE;
      endcase
    end
    flip_ready_d = (state_d == WAIT1) || (state_d == WAIT2);
    game_over_d  = (state_d == WIN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      first_q       <= '0;
      second_q      <= '0;
      map_q         <= '0;
      face_up_q     <= '0;
      matched_q     <= '0;
      moves_q       <= '0;
      pairs_q       <= '0;
      gen_start_q   <= 1'b0;
      flip_ready_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      second_q      <= second_d;
      map_q         <= map_d;
      face_up_q     <= face_up_d;
      matched_q     <= matched_d;
      moves_q       <= moves_d;
      pairs_q       <= pairs_d;
      gen_start_q   <= gen_start_d;
      flip_ready_q  <= flip_ready_d;
      match_pulse_q <= match_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.gen_start  = gen_start_q;
  assign bus.flip_ready = flip_ready_q;
  assign map            = map_q;
  assign matched        = matched_q;
  assign moves          = moves_q;
  assign match_pulse    = match_pulse_q;
  assign miss_pulse     = miss_pulse_q;
  assign game_over      = game_over_q;
`ifdef CARD_MATCH_PEEK_EN
  assign face_up = (peek && state_q == WAIT1) ? '1 : face_up_q;
`else
  assign face_up = face_up_q;
`endif
endmodule

// File: tb/tb_card_match_engine.sv
// Bench for card_match_engine: generator model, game-rule reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_card_match_engine;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        resetn, new_game;
  logic [0:47] map;
  logic [15:0] face_up, matched;
  logic [7:0]  moves;
  logic        match_pulse, miss_pulse, game_over;
  logic [0:47] gm;
  int          n_chk = 0, n_err = 0, n_start = 0;
  bit          started = 0;

  card_match_engine_if bus();

  card_match_engine #(.MISMATCH_HOLD(HOLD), .HOLD_W(3)) dut (
    .clk         (clk),
    .resetn      (resetn),
`ifdef CARD_MATCH_PEEK_EN
    .peek        (1'b0),
`endif
    .bus         (bus),
    .new_game    (new_game),
    .map         (map),
    .face_up     (face_up),
    .matched     (matched),
    .moves       (moves),
    .match_pulse (match_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Generator: gen_done with the fixed map five cycles after a start pulse.
  initial begin
    bus.gen_done = 1'b0;
    bus.gen_map  = '0;
    forever begin
      @(negedge clk);
      if (bus.gen_start === 1'b1) begin
        repeat (4) @(negedge clk);
        bus.gen_done = 1'b1;
        bus.gen_map  = gm;
        @(negedge clk);
        bus.gen_done = 1'b0;
      end
    end
  end

  // Reference model: the game rules as phases over per-card arrays.
  localparam int P_IDLE = 0, P_DEAL = 1, P_PICK1 = 2, P_PICK2 = 3,
                 P_JUDGE = 4, P_SHOW = 5, P_WIN = 6;
  int          ph, mmoves, mpairs, ma, mb, mleft;
  bit          mfu[16], mmt[16];
  int          msym[16];
  logic [0:47] mmap;
  bit          e_start, e_match, e_miss;

  function automatic logic [15:0] pack(input bit a[16]);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = a[i];
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    e_start = 0; e_match = 0; e_miss = 0;
    if (!resetn) begin
      ph = P_IDLE; mmoves = 0; mpairs = 0; mmap = '0;
      for (int i = 0; i < 16; i++) begin mfu[i] = 0; mmt[i] = 0; msym[i] = 0; end
    end else if (new_game && ph != P_DEAL) begin
      ph = P_DEAL; e_start = 1; mmoves = 0; mpairs = 0;
      for (int i = 0; i < 16; i++) begin mfu[i] = 0; mmt[i] = 0; end
    end else begin
      case (ph)
        P_DEAL: if (bus.gen_done) begin
          mmap = bus.gen_map;
          for (int c = 0; c < 16; c++) msym[c] = int'(bus.gen_map[3*c +: 3]);
          ph = P_PICK1;
        end
        P_PICK1: if (bus.flip_valid && !mfu[bus.flip_idx]) begin
          ma = int'(bus.flip_idx); mfu[ma] = 1; ph = P_PICK2;
        end
        P_PICK2: if (bus.flip_valid && !mfu[bus.flip_idx]) begin
          mb = int'(bus.flip_idx); mfu[mb] = 1; ph = P_JUDGE;
        end
        P_JUDGE: begin
          if (mmoves < 255) mmoves++;
          if (msym[ma] == msym[mb]) begin
            mmt[ma] = 1; mmt[mb] = 1; e_match = 1; mpairs++;
            ph = (mpairs == 8) ? P_WIN : P_PICK1;
          end else begin
            mleft = HOLD; ph = P_SHOW;
          end
        end
        P_SHOW: begin
          mleft--;
          if (mleft == 0) begin
            mfu[ma] = 0; mfu[mb] = 0; e_miss = 1; ph = P_PICK1;
          end
        end
        default: ;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      if (bus.gen_start === 1'b1) n_start++;
      check("gen_start",   bus.gen_start,  e_start);
      check("flip_ready",  bus.flip_ready, (ph == P_PICK1 || ph == P_PICK2));
      check("map",         map,            mmap);
      check("face_up",     face_up,        pack(mfu));
      check("matched",     matched,        pack(mmt));
      check("moves",       moves,          mmoves);
      check("match_pulse", match_pulse,    e_match);
      check("miss_pulse",  miss_pulse,     e_miss);
      check("game_over",   game_over,      (ph == P_WIN));
    end
  end

  task automatic flip(input int idx);
    bus.flip_valid = 1'b1;
    bus.flip_idx   = 4'(idx);
    @(negedge clk);
    bus.flip_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.flip_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check(name, bus.flip_ready, 1);
  endtask

  task automatic deal();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    wait_ready("deal_ready");
  endtask

  initial begin
    int cnt;
    for (int c = 0; c < 16; c++) gm[3*c +: 3] = 3'(c >> 1);
    resetn = 1'b0; new_game = 1'b0; bus.flip_valid = 1'b0; bus.flip_idx = '0;
    @(posedge clk); started = 1;
    @(negedge clk);
    check("rst_face_up", face_up, 0);
    check("rst_moves", moves, 0);
    check("rst_map", map, 0);
    check("rst_game_over", game_over, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // First deal: single start pulse, map latched, clean board.
    deal();
    check("deal_starts", n_start, 1);
    check("deal_map", map, gm);
    check("deal_clean", {face_up, matched, moves}, 0);

    // Matching pair 0/1.
    flip(0); flip(1);
    @(negedge clk);
    check("m_pulse", match_pulse, 1);
    check("m_matched", matched, 16'h0003);
    check("m_moves", moves, 1);

    // Mismatch 2/4 on a fresh deal: COMPARE cycle plus the hold window.
    deal();
    flip(2); flip(4);
    cnt = 0;
    while (face_up == 16'h0014 && cnt < 20) begin cnt++; @(negedge clk); end
    check("mm_shown_cycles", cnt, HOLD + 1);
    check("mm_miss", miss_pulse, 1);
    check("mm_face_up", face_up, 0);
    check("mm_moves", moves, 1);

    // Repeated flip and flip during HOLD are dropped.
    flip(3); flip(3);
    check("rep_face_up", face_up, 16'h0008);
    check("rep_moves", moves, 1);
    flip(5);
    @(negedge clk);
    flip(6);
    wait_ready("rep_ready");
    check("rep_after_face_up", face_up, 0);
    check("rep_after_moves", moves, 2);

    // Full game in order.
    deal();
    for (int p = 0; p < 8; p++) begin
      flip(2*p); flip(2*p + 1);
      @(negedge clk);
    end
    check("win_pulse_with_over", {match_pulse, game_over}, 2'b11);
    check("win_moves", moves, 8);
    check("win_matched", matched, 16'hFFFF);

    // new_game in HOLD together with a flip.
    deal();
    flip(0); flip(2);
    repeat (2) @(negedge clk);
    new_game = 1'b1; bus.flip_valid = 1'b1; bus.flip_idx = 4'd5;
    @(negedge clk);
    new_game = 1'b0; bus.flip_valid = 1'b0;
    check("ng_start", bus.gen_start, 1);
    check("ng_clear", {face_up, matched, moves}, 0);
    wait_ready("ng_ready");
    check("ng_no_flip", face_up, 0);

    // Move counter saturation.
    for (int i = 0; i < 260; i++) begin
      flip(0); flip(2);
      wait_ready("sat_ready");
    end
    check("sat_moves", moves, 255);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
